i2c_master_wr: RTL
==================

Name: i2c_master_wr

Overview:
- Parametrised I2C master write engine: START, 7-bit address + W bit, N data bytes, STOP.
- Generates SCL from the system clock through a programmable divider and drives SDA open-drain.
- Samples the slave ACK/NACK on every 9th bit.
- Takes data bytes from an upstream source via a ready pulse; successor to the fixed 0x50/0xAA single-byte test sequencer.

Parameters:
- CLK_DIV, 4, system clocks per SCL quarter-bit phase (>=1); one SCL bit = 4*CLK_DIV clocks.
- CNT_W, 8, width of byte_count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-clock request; sampled only in IDLE.
- dev_addr  in  7  slave address, latched when start accepted.
- byte_count  in  CNT_W  data bytes to write, latched on start; 0 = address-only probe.
- wr_data  in  8  next data byte; must be valid when wr_ready pulses.
- wr_ready  out  1  one-clock pulse: wr_data captured this clock.
- busy  out  1  high from the clock after start is accepted until done.
- done  out  1  one-clock pulse at end of transaction.
- nack  out  1  sticky: slave NACKed; cleared when the next start is accepted.
- i2c_scl  out  1  SCL, push-pull, idle high (no clock stretching).
- i2c_sda_oe  out  1  1 = pull SDA low, 0 = release (external pull-up).
- i2c_sda_in  in  1  SDA pad readback.

Behaviour:
- Reset (asynchronous, reset=0): i2c_scl=1, i2c_sda_oe=0, busy=0, done=0, nack=0, wr_ready=0, state IDLE, counters 0. A reset mid-transfer releases both lines immediately; no STOP is generated.
- Phase counter: divider counts CLK_DIV clocks per phase, 4 phases per bit.
  - Phases 0-1: SCL low; SDA changes only at the start of phase 0.
  - Phases 2-3: SCL high; SDA is stable.
- SDA sampling: i2c_sda_in is sampled on the last clock of phase 2.
- States:
  - IDLE: SCL=1, SDA released. If start=1, latch inputs, clear nack, go START (busy=1 next clock).
  - START: 1 bit time. SCL high; SDA pulled low at end of phase 1; SCL low by phase 3.
  - ADDR: 8 bits MSB first = {dev_addr, 1'b0}.
  - ACK_A: SDA released for 1 bit. Sample 0 -> DATA if byte_count!=0, else STOP. Sample 1 -> nack=1, go STOP.
  - DATA: 8 bits MSB first. On the first clock of the byte's phase 0, capture wr_data and pulse wr_ready.
  - ACK_D: SDA released, sample taken. Sample 1 -> nack=1, go STOP. Sample 0 -> decrement remaining count; nonzero -> DATA, zero -> STOP.
  - STOP: 1 bit time. SDA low with SCL low in phases 0-1; SCL high in phases 2-3; SDA released at start of phase 3.
  - DONE: 1 clock. done=1, busy=0, return to IDLE.
- Total transaction length with all ACKs: (1 + 9 + 9*byte_count + 1) * 4*CLK_DIV clocks from START entry to the done pulse (inclusive of STOP).
- wr_ready is never asserted for the address byte or after a NACK.
- start while busy is ignored; latched values do not change.
- byte_count at max (2^CNT_W-1) must complete without wrap; the count decrements only on a received ACK.
- done and busy deassertion occur on the same clock. start in that clock is ignored; it is accepted in IDLE the following clock.

Test Plan:
1. Reset values: assert reset mid-clock, no clk edge -> scl=1, sda_oe=0, busy/done/nack/wr_ready=0 immediately.
2. CLK_DIV=2, dev_addr=0x50, byte_count=1, wr_data=0xAA, slave ACKs -> SDA bits on SCL rises 1010_0000, ACK, 1010_1010, ACK, STOP. busy for 160 clocks, one wr_ready, one done, nack=0.
3. byte_count=3, wr_data 0x11/0x22/0x33 supplied per wr_ready -> exactly 3 wr_ready pulses, each before the first SCL rise of its byte. Bytes appear in order; 9 SCL pulses per byte.
4. Address NACK (sda_in=1 at ACK_A), byte_count=2 -> nack=1, zero wr_ready, STOP generated, transaction 88 clocks (CLK_DIV=2); nack stays 1 until the next start.
5. byte_count=3, NACK on 2nd data byte -> 2 wr_ready pulses, nack=1, STOP right after ACK_D; start pulsed during busy has no effect.
6. Reset asserted during DATA bit 4 -> lines released asynchronously, no STOP. After release, a new start with byte_count=0 yields an address-only probe of 11 bits = 88 clocks.

Source files
------------

// File: rtl/i2c_master_wr.sv
// I2C master write engine: START, address + W, byte_count data bytes pulled from an upstream
// source via wr_ready, STOP. SCL is push-pull from a phase divider, SDA is open-drain via sda_oe.
module i2c_master_wr #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       dev_addr,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             i2c_scl,
  output logic             i2c_sda_oe,
  input  logic             i2c_sda_in
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAckA, StData, StAckD, StStop, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             smp_q, smp_d;
  logic             nack_q, nack_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic             wr_ready_q, wr_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick, bit_end;

  always_comb begin
    tick    = (div_q == DivLast);
    bit_end = tick && (phase_q == 2'd3);

    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    remain_d = remain_q;
    smp_d    = smp_q;
    nack_d   = nack_q;

    if (state_q != StIdle && state_q != StDone) begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) phase_d = phase_q + 2'd1;
    end

    if ((state_q == StAckA || state_q == StAckD) && tick && phase_q == 2'd2) begin
      smp_d = i2c_sda_in;
    end

    // Byte is captured on the edge closing the wr_ready clock.
    if (state_q == StData && wr_ready_q) shift_d = wr_data;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StStart;
          div_d    = '0;
          phase_d  = '0;
          bit_d    = '0;
          shift_d  = {dev_addr, 1'b0};
          remain_d = byte_count;
          nack_d   = 1'b0;
        end
      end
      StStart: if (bit_end) state_d = StAddr;
      StAddr, StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = (state_q == StAddr) ? StAckA : StAckD;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      StAckA: begin
        if (bit_end) begin
          if (smp_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            state_d = (remain_q != '0) ? StData : StStop;
          end
        end
      end
      StAckD: begin
        if (bit_end) begin
          if (smp_q) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            remain_d = remain_q - CNT_W'(1);
            state_d  = (remain_q == CNT_W'(1)) ? StStop : StData;
          end
        end
      end
      StStop: if (bit_end) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    wr_ready_d = (state_d == StData) && (state_q != StData);
    busy_d     = !(state_d inside {StIdle, StDone});
    done_d     = (state_d == StDone);
    scl_d      = 1'b1;
    sda_oe_d   = 1'b0;
    case (state_d)
      StStart: begin
        scl_d    = (phase_d != 2'd3);
        sda_oe_d = phase_d[1];
      end
      StAddr, StData: begin
        scl_d    = phase_d[1];
        // SDA stays released for the one clock in which the data byte is still being fetched.
        sda_oe_d = wr_ready_d ? 1'b0 : ~shift_d[7];
      end
      StAckA, StAckD: scl_d = phase_d[1];
      StStop: begin
        scl_d    = phase_d[1];
        sda_oe_d = (phase_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      remain_q   <= '0;
      smp_q      <= 1'b0;
      nack_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      remain_q   <= remain_d;
      smp_q      <= smp_d;
      nack_q     <= nack_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;
  assign i2c_scl    = scl_q;
  assign i2c_sda_oe = sda_oe_q;

endmodule
